multi_alarm_watch_core: RTL
===========================

// Module: multi_alarm_watch_core
// PURPOSE
//  Parametrised next-gen timekeeping core: HH:MM:SS clock from a clock prescaler, NUM_ALARMS
//  independent alarms with enable, snooze and auto-timeout ringing, and 12/24h display.
//  Driven by the same mode/set button pulses as the watch FSM.
//  Sits beside the stopwatch under the watch top level and drives the BCD display digits.
// PARAMETERS
//  TICKS_PER_SEC  1000  clk cycles per second (>=1)
//  NUM_ALARMS     4     number of alarm slots (1..8)
//  SNOOZE_MIN     5     snooze delay in minutes (1..59)
//  RING_SEC       60    seconds of ringing before auto-off (1..255)
// PORTS
//  clk                input  1   system clock
//  rst                input  1   asynchronous, active-high reset
//  mode               input  1   1-cycle pulse: advance edit field / dismiss ring
//  set                input  1   1-cycle pulse: increment field / dismiss ring
//  snooze             input  1   1-cycle pulse: snooze while ringing
//  fmt_12h            input  1   1 = 12h display, 0 = 24h display
//  tens_hours_out     output 2   hours tens digit (BCD)
//  units_hours_out    output 4   hours units digit (BCD)
//  tens_minutes_out   output 3   minutes tens digit (BCD)
//  units_minutes_out  output 4   minutes units digit (BCD)
//  pm_out             output 1   1 when hour>=12 (valid in both formats)
//  sec_out            output 6   seconds, binary 0..59
//  edit_alarm         output AW  alarm slot being edited, AW=$clog2(NUM_ALARMS) min 1
//  edit_field         output 3   current FSM state encoding (see package)
//  alarm_sound        output 1   ringing
//  alarm_id           output AW  slot that caused current/last ring
// BEHAVIOUR
//  Reset: time 00:00:00, prescaler 0, all alarms 00:00 disabled, state NORMAL, edit_alarm 0,
//   alarm_sound 0, alarm_id 0, snooze pending cleared. Reset mid-ring/mid-edit: same values.
//  Timebase: presc counts 0..TICKS_PER_SEC-1; sec_tick on wrap. sec 59->0 increments min;
//   min 59->0 increments hour; hour 23->0. Time held internally binary; BCD combinational.
//  Display: shows edited alarm's HH:MM in ALM_* states, else current time. 12h: hour 0->12,
//   13..23 -> 1..11; pm_out = hour>=12. Digit outputs combinational from registers.
//  FSM: NORMAL -mode-> SET_HR -mode-> SET_MIN -mode-> ALM_HR -mode-> ALM_MIN -mode-> ALM_EN
//   -mode-> ALM_HR of slot i+1; after ALM_EN of last slot -> NORMAL, edit_alarm returns 0.
//  set in SET_HR/ALM_HR: hour+1 wrap 23->0; SET_MIN/ALM_MIN: min+1 wrap 59->0;
//   ALM_EN: toggle enable. set in NORMAL (not ringing): no effect.
//  SET_HR/SET_MIN: presc and sec frozen; on SET_MIN->ALM_HR sec and presc cleared to 0.
//   Alarm states: time keeps running.
//  Trigger: in cycle with sec==0 && presc==0 && state not SET_HR/SET_MIN, an enabled slot whose
//   HH:MM equals time (or pending snooze target matching) -> alarm_sound=1 next cycle,
//   alarm_id latched. Several matches: lowest index wins. Match while ringing: ignored.
//  New slot trigger cancels any pending snooze.
//  Ringing: ring counter counts sec_ticks; after RING_SEC ticks alarm_sound->0 (no snooze set).
//  snooze while ringing: sound 0 next cycle; snooze target = time + SNOOZE_MIN min mod 24h;
//   re-rings at target with same alarm_id. snooze when not ringing: ignored.
//  mode or set while ringing: dismiss only (sound 0, snooze cleared); no FSM step/increment.
//  Simultaneous: mode+set same cycle -> mode only. snooze+mode/set while ringing -> dismiss.
//  Disabling a slot does not stop a ring already in progress.
// STRUCTURE
//  Package watch_pkg: state enum (NORMAL,SET_HR,SET_MIN,ALM_HR,ALM_MIN,ALM_EN, 3-bit),
//   constants MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59, BCD split function.
//  Sub-module watch_alarm_slot (xNUM_ALARMS via generate): hour/min/enable regs, edit inputs,
//   registered-free match output. Top holds prescaler, time, FSM, ring/snooze logic.
// TESTING (TICKS_PER_SEC=2, RING_SEC=4, SNOOZE_MIN=5)
//  1 Preload 23:59:59, one sec_tick -> 00:00:00; fmt_12h=1 -> digits 1,2,0,0, pm_out=0.
//  2 From reset: mode, set x3, mode, set x2, mode -> time 03:02:00, state ALM_HR, edit_alarm 0.
//  3 Slot1=06:30 enabled, run to 06:30:00 -> alarm_sound=1 next cycle, alarm_id=1; 0 after 4 s.
//  4 Ring at 23:58, snooze -> sound 0, re-ring at 00:03:00 alarm_id kept; set -> sound 0.
//  5 Slots 0 and 2 both 07:00 enabled -> alarm_id=0; rst asserted mid-ring -> all reset values.
//  6 mode+set same cycle in SET_HR -> advances to SET_MIN, hour unchanged.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared definitions for the multi-alarm watch core.
//   state_t    : edit/display FSM state (3-bit, also exported as edit_field)
//   MAX_*      : wrap points of the binary time registers
//   bcd_split  : binary 0..99 -> {tens, units} BCD nibbles
package watch_pkg;

  typedef enum logic [2:0] {
    NORMAL  = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    ALM_HR  = 3'd3,
    ALM_MIN = 3'd4,
    ALM_EN  = 3'd5
  } state_t;

  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_SEC  = 6'd59;

  function automatic logic [7:0] bcd_split(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/watch_alarm_slot.sv
// One alarm slot: stored HH:MM plus enable, edited by single-cycle strobes.
//   clk, rst            : clock, asynchronous active-high reset
//   inc_hour/inc_min    : increment stored hour (wrap 23->0) / minute (wrap 59->0)
//   tog_en              : toggle enable
//   cur_hour/cur_min    : current time of day
//   alm_hour/alm_min    : stored alarm time (for display)
//   match               : combinational, enabled and HH:MM equals current time
module watch_alarm_slot
  import watch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       tog_en,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic [4:0] alm_hour,
  output logic [5:0] alm_min,
  output logic       match
);

  logic alm_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alm_hour <= '0;
      alm_min  <= '0;
      alm_en   <= 1'b0;
    end else begin
      if (inc_hour) alm_hour <= (alm_hour == MAX_HOUR) ? '0 : alm_hour + 5'd1;
      if (inc_min)  alm_min  <= (alm_min == MAX_MIN) ? '0 : alm_min + 6'd1;
      if (tog_en)   alm_en   <= ~alm_en;
    end
  end

  assign match = alm_en && (alm_hour == cur_hour) && (alm_min == cur_min);

endmodule

// File: rtl/multi_alarm_watch_core.sv
// Timekeeping core: HH:MM:SS from a clock prescaler, NUM_ALARMS alarm slots with
// enable / snooze / auto-timeout ringing, 12/24h BCD display.
//   clk, rst                 : clock, asynchronous active-high reset
//   mode, set, snooze        : 1-cycle button pulses
//   fmt_12h                  : 1 = 12h display
//   *_hours_out/*_minutes_out: BCD digits of displayed HH:MM
//   pm_out                   : displayed hour >= 12
//   sec_out                  : seconds (binary)
//   edit_alarm, edit_field   : slot being edited, FSM state
//   alarm_sound, alarm_id    : ringing, slot that caused the current/last ring
module multi_alarm_watch_core
  import watch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int NUM_ALARMS    = 4,
  parameter int SNOOZE_MIN    = 5,
  parameter int RING_SEC      = 60,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic          set,
  input  logic          snooze,
  input  logic          fmt_12h,
  output logic [1:0]    tens_hours_out,
  output logic [3:0]    units_hours_out,
  output logic [2:0]    tens_minutes_out,
  output logic [3:0]    units_minutes_out,
  output logic          pm_out,
  output logic [5:0]    sec_out,
  output logic [AW-1:0] edit_alarm,
  output logic [2:0]    edit_field,
  output logic          alarm_sound,
  output logic [AW-1:0] alarm_id
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  state_t          state;
  logic [PW-1:0]   presc;
  logic [5:0]      sec, min;
  logic [4:0]      hour;
  logic [7:0]      ring_cnt;
  logic            snz_pend;
  logic [4:0]      snz_hour;
  logic [5:0]      snz_min;

  logic [4:0]            slot_hour [NUM_ALARMS];
  logic [5:0]            slot_min  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] slot_match, inc_hour, inc_min, tog_en;

  logic frozen, sec_tick, at_minute, do_mode, do_set, hit, in_alm;
  logic [AW-1:0] hit_id;
  logic [6:0]    snz_sum;
  logic [4:0]    tgt_hour, disp_hour, shown_hour;
  logic [5:0]    tgt_min, disp_min;

  assign frozen    = (state == SET_HR) || (state == SET_MIN);
  assign sec_tick  = !frozen && (presc == PW'(TICKS_PER_SEC - 1));
  assign at_minute = !frozen && (sec == '0) && (presc == '0);
  // While ringing, mode/set only dismiss; mode takes priority over set.
  assign do_mode   = mode && !alarm_sound;
  assign do_set    = set && !mode && !alarm_sound;

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
    logic sel;
    assign sel         = do_set && (edit_alarm == AW'(i));
    assign inc_hour[i] = sel && (state == ALM_HR);
    assign inc_min[i]  = sel && (state == ALM_MIN);
    assign tog_en[i]   = sel && (state == ALM_EN);

    watch_alarm_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .inc_hour (inc_hour[i]),
      .inc_min  (inc_min[i]),
      .tog_en   (tog_en[i]),
      .cur_hour (hour),
      .cur_min  (min),
      .alm_hour (slot_hour[i]),
      .alm_min  (slot_min[i]),
      .match    (slot_match[i])
    );
  end

  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (!hit && slot_match[i]) begin
        hit    = 1'b1;
        hit_id = AW'(i);
      end
    end
  end

  always_comb begin
    snz_sum  = {1'b0, min} + 7'(SNOOZE_MIN);
    tgt_hour = hour;
    tgt_min  = snz_sum[5:0];
    if (snz_sum > 7'd59) begin
      tgt_min  = 6'(snz_sum - 7'd60);
      tgt_hour = (hour == MAX_HOUR) ? '0 : hour + 5'd1;
    end
  end

  always_comb begin
    in_alm    = (state == ALM_HR) || (state == ALM_MIN) || (state == ALM_EN);
    disp_hour = in_alm ? slot_hour[edit_alarm] : hour;
    disp_min  = in_alm ? slot_min[edit_alarm] : min;
    shown_hour = disp_hour;
    if (fmt_12h) begin
      if (disp_hour == 5'd0)       shown_hour = 5'd12;
      else if (disp_hour > 5'd12)  shown_hour = disp_hour - 5'd12;
    end
  end

  assign {tens_hours_out, units_hours_out}     = 6'(bcd_split(7'(shown_hour)));
  assign {tens_minutes_out, units_minutes_out} = 7'(bcd_split(7'(disp_min)));
  assign pm_out     = disp_hour >= 5'd12;
  assign sec_out    = sec;
  assign edit_field = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= NORMAL;
      edit_alarm  <= '0;
      presc       <= '0;
      sec         <= '0;
      min         <= '0;
      hour        <= '0;
      alarm_sound <= 1'b0;
      alarm_id    <= '0;
      ring_cnt    <= '0;
      snz_pend    <= 1'b0;
      snz_hour    <= '0;
      snz_min     <= '0;
    end else begin
      if (!frozen) begin
        if (sec_tick) begin
          presc <= '0;
          if (sec == MAX_SEC) begin
            sec <= '0;
            if (min == MAX_MIN) begin
              min  <= '0;
              hour <= (hour == MAX_HOUR) ? '0 : hour + 5'd1;
            end else begin
              min <= min + 6'd1;
            end
          end else begin
            sec <= sec + 6'd1;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end

      // Time edits only happen while frozen, so they never collide with the timebase.
      if (do_set && state == SET_HR)  hour <= (hour == MAX_HOUR) ? '0 : hour + 5'd1;
      if (do_set && state == SET_MIN) min  <= (min == MAX_MIN) ? '0 : min + 6'd1;

      if (do_mode) begin
        case (state)
          NORMAL:  state <= SET_HR;
          SET_HR:  state <= SET_MIN;
          SET_MIN: begin
            state <= ALM_HR;
            sec   <= '0;
            presc <= '0;
          end
          ALM_HR:  state <= ALM_MIN;
          ALM_MIN: state <= ALM_EN;
          ALM_EN: begin
            if (edit_alarm == AW'(NUM_ALARMS - 1)) begin
              state      <= NORMAL;
              edit_alarm <= '0;
            end else begin
              state      <= ALM_HR;
              edit_alarm <= edit_alarm + AW'(1);
            end
          end
          default: state <= NORMAL;
        endcase
      end

      if (alarm_sound) begin
        if (mode || set) begin
          alarm_sound <= 1'b0;
          snz_pend    <= 1'b0;
        end else if (snooze) begin
          alarm_sound <= 1'b0;
          snz_pend    <= 1'b1;
          snz_hour    <= tgt_hour;
          snz_min     <= tgt_min;
        end else if (sec_tick) begin
          if (ring_cnt == 8'(RING_SEC - 1)) alarm_sound <= 1'b0;
          else                              ring_cnt    <= ring_cnt + 8'd1;
        end
      end else if (at_minute) begin
        // A fresh slot match wins over (and cancels) a pending snooze.
        if (hit) begin
          alarm_sound <= 1'b1;
          alarm_id    <= hit_id;
          ring_cnt    <= '0;
          snz_pend    <= 1'b0;
        end else if (snz_pend && snz_hour == hour && snz_min == min) begin
          alarm_sound <= 1'b1;
          ring_cnt    <= '0;
          snz_pend    <= 1'b0;
        end
      end
    end
  end

endmodule
